regfile_mp: RTL and testbench

Parametrised multi-port register file, the successor to regfile_32bit. It generalises read and write port counts and adds an optional hardwired zero register, write-to-read bypass, and a per-register busy scoreboard so the issue stage can detect pending producers. It sits between decode/issue (read ports, reservations) and writeback (write ports) in the 32-bit processor datapath.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 95 +++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   localparam int RF_RWIDTH = 6;
   localparam int RF_DWIDTH = 32;

   // Upper bound on write ports understood by the writer-select helper.
   localparam int RF_MAXWR  = 8;
   localparam int RF_WIDX   = 3;

   typedef logic [RF_RWIDTH-1:0] rf_addr_t;
   typedef logic [RF_DWIDTH-1:0] rf_data_t;

   typedef struct packed {
      logic               hit;
      logic [RF_WIDX-1:0] idx;
   } rf_sel_t;

   // Picks the highest-index writer among the matching ports; hit=0 if none match.
   function automatic rf_sel_t rf_hi_writer(input logic [RF_MAXWR-1:0] hits);
      rf_sel_t s;
      s = '0;
      for (int i = 0; i < RF_MAXWR; i++) begin
         if (hits[i]) begin
            s.hit = 1'b1;
            s.idx = RF_WIDX'(i);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: reservations set, writes clear, reservation wins a tie.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int RWIDTH   = RF_RWIDTH,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2**RWIDTH-1:0]   clr,
   input  logic                   rsv_en,
   input  logic [RWIDTH-1:0]      rsv_addr,
   input  logic [NRD*RWIDTH-1:0]  ra,
   input  logic [NRD-1:0]         fwd,
   output logic [NRD-1:0]         rd_busy
);

   localparam int DEPTH = 2**RWIDTH;

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] set;

   // Decode the reservation; register 0 can never become busy when hardwired.
   always_comb begin
      set = '0;
      if (rsv_en) set[rsv_addr] = 1'b1;
      if (ZERO_REG != 0) set[0] = 1'b0;
   end

   // Busy vector: a new producer supersedes a completing write to the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= (busy & ~clr) | set;
   end

   // Per-port lookup; forwarded data means the value is already available.
   always_comb begin
      logic [RWIDTH-1:0] a;
      rd_busy = '0;
      for (int p = 0; p < NRD; p++) begin
         a = ra[p*RWIDTH +: RWIDTH];
         rd_busy[p] = busy[a] && !fwd[p] && !((ZERO_REG != 0) && (a == '0));
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional zero register,
// write-to-read bypass and a busy scoreboard for the issue stage.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int RWIDTH   = RF_RWIDTH,
   parameter int DWIDTH   = RF_DWIDTH,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NRD*RWIDTH-1:0]  ra,
   output logic [NRD*DWIDTH-1:0]  rd,
   output logic [NRD-1:0]         rd_busy,
   input  logic [NWR-1:0]         we,
   input  logic [NWR*RWIDTH-1:0]  wa,
   input  logic [NWR*DWIDTH-1:0]  wd,
   input  logic                   rsv_en,
   input  logic [RWIDTH-1:0]      rsv_addr
);

   localparam int DEPTH = 2**RWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   rf_sel_t           wr_sel [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic [NRD-1:0]    byp_hit;

   // Per-register winning writer (highest port index); register 0 is never written when hardwired.
   always_comb begin
      logic [RF_MAXWR-1:0] hits;
      for (int r = 0; r < DEPTH; r++) begin
         hits = '0;
         for (int i = 0; i < NWR; i++)
            hits[i] = we[i] && (wa[i*RWIDTH +: RWIDTH] == RWIDTH'(r));
         if ((ZERO_REG != 0) && (r == 0)) hits = '0;
         wr_sel[r] = rf_hi_writer(hits);
         wr_hit[r] = wr_sel[r].hit;
      end
   end

   // Storage array; reset clears every entry immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++)
            if (wr_sel[r].hit)
               mem[r] <= wd[int'(wr_sel[r].idx)*DWIDTH +: DWIDTH];
      end
   end

   // Combinational read ports; bypass is gated by reset so rd reads 0 while held.
   always_comb begin
      logic [RF_MAXWR-1:0] hits;
      logic [RWIDTH-1:0]   a;
      rf_sel_t             sel;
      rd      = '0;
      byp_hit = '0;
      for (int p = 0; p < NRD; p++) begin
         a    = ra[p*RWIDTH +: RWIDTH];
         hits = '0;
         for (int i = 0; i < NWR; i++)
            hits[i] = rst_n && we[i] && (wa[i*RWIDTH +: RWIDTH] == a);
         sel = rf_hi_writer(hits);
         if ((ZERO_REG != 0) && (a == '0)) begin
            rd[p*DWIDTH +: DWIDTH] = '0;
         end else if ((BYPASS != 0) && sel.hit) begin
            rd[p*DWIDTH +: DWIDTH] = wd[int'(sel.idx)*DWIDTH +: DWIDTH];
            byp_hit[p]             = 1'b1;
         end else begin
            rd[p*DWIDTH +: DWIDTH] = mem[a];
         end
      end
   end

   regfile_scoreboard #(
      .RWIDTH   (RWIDTH),
      .NRD      (NRD),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (wr_hit),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .ra       (ra),
      .fwd      (byp_hit),
      .rd_busy  (rd_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: one bypassing and one non-bypassing instance share stimulus;
// expected port values are queued when driven and popped when sampled.
module tb_regfile_mp;

   localparam int RW  = 6;
   localparam int DW  = 32;
   localparam int NRD = 3;
   localparam int NWR = 2;

   logic                clk;
   logic                rst_n;
   logic [NRD*RW-1:0]   ra;
   logic [NRD*DW-1:0]   rd_b, rd_n;
   logic [NRD-1:0]      busy_b, busy_n;
   logic [NWR-1:0]      we;
   logic [NWR*RW-1:0]   wa;
   logic [NWR*DW-1:0]   wd;
   logic                rsv_en;
   logic [RW-1:0]       rsv_addr;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      string       tag;
      bit          nb;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   exp_t sb[$];

   regfile_mp #(.RWIDTH(RW), .DWIDTH(DW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_b), .rd_busy(busy_b),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
   );

   regfile_mp #(.RWIDTH(RW), .DWIDTH(DW), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd_n), .rd_busy(busy_n),
      .we(we), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_rd(input string tag, input bit nb, input int port,
                            input logic [31:0] data, input logic busy);
      exp_t e;
      e.tag = tag; e.nb = nb; e.port = port; e.data = data; e.busy = busy;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [31:0] od;
      logic        ob;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         od = e.nb ? rd_n[e.port*DW +: DW] : rd_b[e.port*DW +: DW];
         ob = e.nb ? busy_n[e.port] : busy_b[e.port];
         vectors++;
         assert (od === e.data) else begin
            miscompares++;
            $error("FAIL %s nb=%0d port=%0d rd got=%h want=%h", e.tag, e.nb, e.port, od, e.data);
         end
         vectors++;
         assert (ob === e.busy) else begin
            miscompares++;
            $error("FAIL %s nb=%0d port=%0d busy got=%b want=%b", e.tag, e.nb, e.port, ob, e.busy);
         end
      end
   endtask

   task automatic both(input string tag, input int port, input logic [31:0] dbyp,
                       input logic bbyp, input logic [31:0] dnb, input logic bnb);
      expect_rd(tag, 1'b0, port, dbyp, bbyp);
      expect_rd(tag, 1'b1, port, dnb, bnb);
   endtask

   task automatic set_ra(input int p, input logic [RW-1:0] a);
      ra[p*RW +: RW] = a;
   endtask

   task automatic set_wr(input int i, input logic [RW-1:0] a, input logic [31:0] d);
      we[i]          = 1'b1;
      wa[i*RW +: RW] = a;
      wd[i*DW +: DW] = d;
   endtask

   task automatic idle();
      we = '0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_addr = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      ra    = '0;
      idle();

      // reset state, all ports
      set_ra(0, 6'd5); set_ra(1, 6'd12); set_ra(2, 6'd63);
      #1;
      for (int p = 0; p < NRD; p++) both("reset_init", p, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      rst_n = 1'b1;

      // write reg 5, then async reset wipes it
      set_wr(0, 6'd5, 32'hDEADBEEF);
      #1;
      both("wr5_same", 0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("wr5_after", 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
      check();
      #2;
      rst_n = 1'b0;
      #1;
      both("reset_async", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      set_wr(0, 6'd5, 32'h00000123);
      rsv_en = 1'b1; rsv_addr = 6'd5;
      #1;
      both("reset_wr_ign", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      #1;
      both("reset_hold", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      idle();
      rst_n = 1'b1;
      #1;
      both("reset_rel", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();

      // write/read reg 12, bypass vs no bypass
      @(negedge clk);
      set_ra(0, 6'd12);
      set_wr(0, 6'd12, 32'hAAAAAAAA);
      #1;
      both("wr12_same", 0, 32'hAAAAAAAA, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("wr12_after", 0, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA, 1'b0);
      check();

      // zero register: write and reservation ignored
      set_ra(0, 6'd0);
      set_wr(0, 6'd0, 32'hFFAAFFAA);
      rsv_en = 1'b1; rsv_addr = 6'd0;
      #1;
      both("zero_same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("zero_after", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();

      // write collision on reg 63, port 1 wins
      set_ra(1, 6'd63);
      set_wr(0, 6'd63, 32'h11111111);
      set_wr(1, 6'd63, 32'h22222222);
      #1;
      both("coll_same", 1, 32'h22222222, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("coll_after", 1, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
      check();

      // scoreboard: reserve reg 9
      set_ra(0, 6'd9);
      rsv_en = 1'b1; rsv_addr = 6'd9;
      #1;
      both("rsv9_same", 0, 32'h0, 1'b0, 32'h0, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("rsv9_after", 0, 32'h0, 1'b1, 32'h0, 1'b1);
      check();

      // write to 9 clears busy
      set_wr(0, 6'd9, 32'h5A5A5A5A);
      #1;
      both("clr9_same", 0, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1);
      check();
      @(negedge clk);
      idle();
      #1;
      both("clr9_after", 0, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 1'b0);
      check();

      // reserve and write 9 together: data updates, busy stays set
      set_wr(0, 6'd9, 32'h12345678);
      rsv_en = 1'b1; rsv_addr = 6'd9;
      #1;
      both("rw9_same", 0, 32'h12345678, 1'b0, 32'h5A5A5A5A, 1'b0);
      check();
      @(negedge clk);
      idle();
      #1;
      both("rw9_after", 0, 32'h12345678, 1'b1, 32'h12345678, 1'b1);
      check();

      // multi-port read {12,12,63}
      ra = {6'd12, 6'd12, 6'd63};
      #1;
      both("mp_p0", 0, 32'h22222222, 1'b0, 32'h22222222, 1'b0);
      both("mp_p1", 1, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA, 1'b0);
      both("mp_p2", 2, 32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA, 1'b0);
      check();

      // same busy register seen on every port
      ra = {6'd9, 6'd9, 6'd9};
      #1;
      for (int p = 0; p < NRD; p++) both("mp_busy", p, 32'h12345678, 1'b1, 32'h12345678, 1'b1);
      check();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
